// File: rtl/alu_tx_pkg.sv
// Shared types and helpers for the ALU result UART transmitter.
package alu_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_tx_baud_tick.sv
// Baud divider: down-counter that pulses bit_done_o once every CLKS_PER_BIT cycles
// while enabled; clr_i restarts a full bit time.
module alu_tx_baud_tick
  import alu_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_done_o
);

  localparam int W = cnt_w(CLKS_PER_BIT);
  localparam logic [W-1:0] LOAD = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)               cnt_d = LOAD;
    else if (!en_i)          cnt_d = '0;
    else if (cnt_q == '0)    cnt_d = LOAD;
    else                     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_done_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/alu_result_uart_tx.sv
// 8N1 (or 8E1 with ALU_TX_PARITY_EN) UART transmitter for ALU results with a
// one-entry holding register so frames can run back to back.
module alu_result_uart_tx
  import alu_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy
);

  localparam int IDX_W = cnt_w(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              serial_q, serial_d;
  logic              bit_done, baud_clr, accept;
`ifdef ALU_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  alu_tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q != IDLE),
    .clr_i      (baud_clr),
    .bit_done_o (bit_done)
  );

  assign accept = tx_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    idx_d       = idx_q;
    baud_clr    = 1'b0;
`ifdef ALU_TX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        shift_d  = tx_data;
        state_d  = START;
        baud_clr = 1'b1;
`ifdef ALU_TX_PARITY_EN
        par_d    = ^tx_data;
`endif
      end
      START: if (bit_done) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_done) begin
        shift_d = shift_q >> 1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef ALU_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef ALU_TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP: if (bit_done) begin
        // A held word, or one offered on this very edge, starts with no idle bit.
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
`ifdef ALU_TX_PARITY_EN
          par_d       = ^hold_q;
`endif
        end else if (accept) begin
          shift_d = tx_data;
          state_d = START;
`ifdef ALU_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && state_q != IDLE && !(state_q == STOP && bit_done)) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    serial_d = LINE_IDLE;
    case (state_q)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_q[0];
`ifdef ALU_TX_PARITY_EN
      PARITY:  serial_d = par_q;
`endif
      default: serial_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      serial_q    <= LINE_IDLE;
`ifdef ALU_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      serial_q    <= serial_d;
`ifdef ALU_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx_ready  = !hold_full_q;
  assign tx_serial = serial_q;
  assign tx_busy   = (state_q != IDLE);

endmodule
